// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one banked memory between the I-cache and D-cache
// controllers. It serialises whole-word reads/writes, absorbs bank stalls and returns read data.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              d_stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT1,
    WAIT2,
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;   // 0 = I port, 1 = D port
  logic                wr_reg, wr_next;
  logic                err_reg, err_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;

  logic i_req, d_req, grant_i;
  logic sel_rd, sel_wr;

  assign i_req   = i_rd | i_wr;
  assign d_req   = d_rd | d_wr;
  assign grant_i = i_req & (~d_req | (starve_reg == STARVE_MAX));
  assign sel_rd  = grant_i ? i_rd : d_rd;
  assign sel_wr  = grant_i ? i_wr : d_wr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      wr_reg     <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      wr_reg     <= wr_next;
      err_reg    <= err_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    wr_next     = wr_reg;
    err_next    = err_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    starve_next = starve_reg;
    case (state_reg)
      IDLE: begin
        if (i_req | d_req) begin
          owner_next = ~grant_i;
          wr_next    = sel_wr;
          err_next   = sel_rd & sel_wr;
          addr_next  = grant_i ? i_addr : d_addr;
          wdata_next = grant_i ? i_wdata : d_wdata;
          // Cleared so writes and illegal requests never return stale read data.
          rdata_next = '0;
          state_next = (sel_rd & sel_wr) ? DONE : ISSUE;
          if (grant_i) begin
            starve_next = '0;
          end else if (i_req && (starve_reg != STARVE_MAX)) begin
            starve_next = starve_reg + STARVE_W'(1);
          end
        end
      end
      ISSUE: begin
        if (!mem_stall) begin
          state_next = wr_reg ? DONE : WAIT1;
        end
      end
      WAIT1:   state_next = WAIT2;
      WAIT2: begin
        rdata_next = mem_rdata;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic                in_issue;
  logic [1:0]          done_vec;
  logic [1:0]          err_vec;
  logic [DATA_W-1:0]   rdata_vec [2];

  assign in_issue  = (state_reg == ISSUE);
  assign mem_rd    = in_issue & ~wr_reg;
  assign mem_wr    = in_issue & wr_reg;
  assign mem_addr  = in_issue ? addr_reg : '0;
  assign mem_wdata = in_issue ? wdata_reg : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign done_vec[gi]  = (state_reg == DONE) && (owner_reg == 1'(gi));
    assign err_vec[gi]   = done_vec[gi] & err_reg;
    assign rdata_vec[gi] = done_vec[gi] ? rdata_reg : '0;
  end

  assign i_done  = done_vec[0];
  assign d_done  = done_vec[1];
  assign i_err   = err_vec[0];
  assign d_err   = err_vec[1];
  assign i_rdata = rdata_vec[0];
  assign d_rdata = rdata_vec[1];
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: a transaction-level reference predicts
// grant order, memory command windows and completion cycles; a monitor checks the DUT against it.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 2;
  localparam int NST = 8192;

  logic clk = 1'b0;
  logic rst;
  logic          rd_a [2];
  logic          wr_a [2];
  logic [AW-1:0] addr_a [2];
  logic [DW-1:0] wdata_a [2];
  logic [DW-1:0] i_rdata, d_rdata, mem_rdata;
  logic          i_done, i_err, i_stall, d_done, d_err, d_stall;
  logic          mem_rd, mem_wr, mem_stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit stall_at [NST];
  bit act [2];
  bit seen [2];
  bit rst_prev = 1'b1;

  typedef struct {
    int            port;
    int            done_cyc;
    int            iss_start;
    int            iss_end;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t q [$];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_rd(rd_a[0]), .i_wr(wr_a[0]), .i_addr(addr_a[0]), .i_wdata(wdata_a[0]),
    .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err), .i_stall(i_stall),
    .d_rd(rd_a[1]), .d_wr(wr_a[1]), .d_addr(addr_a[1]), .d_wdata(wdata_a[1]),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err), .d_stall(d_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(logic [3:0] a);
    return {4'hA, a, ~a, a};
  endfunction

  function automatic bit st(int c);
    return (c >= 0 && c < NST) ? stall_at[c] : 1'b0;
  endfunction

  // Memory model: 16 words (low address bits), read data appears two cycles after acceptance.
  logic [DW-1:0] mem_m [16];
  bit            written [16];
  logic [DW-1:0] pipe1 = '0;
  logic [DW-1:0] pipe2 = '0;
  assign mem_rdata = pipe2;

  function automatic logic [DW-1:0] mem_val(logic [3:0] a);
    return written[a] ? mem_m[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wr && !mem_stall) begin
      mem_m[mem_addr[3:0]]   <= mem_wdata;
      written[mem_addr[3:0]] <= 1'b1;
    end
    pipe2 <= pipe1;
    pipe1 <= (mem_rd && !mem_stall) ? mem_val(mem_addr[3:0]) : '0;
  end

  initial begin
    mem_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_stall = st(cyc);
    end
  end

  task automatic chk(string name, logic [63:0] act_v, logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act_v, exp_v);
    end
  endtask

  // Reference model: transactions serialise; one free cycle between them; D wins unless
  // I has waited through LIM consecutive D grants or D is silent.
  initial begin : reference
    logic [DW-1:0] ref_mem [16];
    int starve = 0;
    int free_c = 0;
    for (int a = 0; a < 16; a++) ref_mem[a] = init_val(4'(a));
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        while (q.size() > 0 && q[q.size()-1].done_cyc > cyc) void'(q.pop_back());
        starve = 0;
        free_c = cyc + 1;
      end else if (cyc >= free_c && (rd_a[0] | wr_a[0] | rd_a[1] | wr_a[1])) begin
        exp_t e;
        bit   ireq, dreq;
        int   p, s;
        ireq = rd_a[0] | wr_a[0];
        dreq = rd_a[1] | wr_a[1];
        p = (ireq && (!dreq || starve == LIM)) ? 0 : 1;
        if (p == 0) starve = 0;
        else if (ireq && starve < LIM) starve++;
        e.port  = p;
        e.rd    = rd_a[p];
        e.wr    = wr_a[p];
        e.addr  = addr_a[p];
        e.wdata = wdata_a[p];
        e.rdata = '0;
        if (e.rd && e.wr) begin
          e.iss_start = -1;
          e.iss_end   = -2;
          e.done_cyc  = cyc + 1;
        end else begin
          s = cyc + 1;
          while (st(s)) s++;
          e.iss_start = cyc + 1;
          e.iss_end   = s;
          e.done_cyc  = e.wr ? s + 1 : s + 3;
          if (e.wr) ref_mem[e.addr[3:0]] = e.wdata;
          else      e.rdata = ref_mem[e.addr[3:0]];
        end
        free_c = e.done_cyc + 1;
        q.push_back(e);
      end
    end
  end

  initial begin : monitor
    forever begin
      exp_t e;
      bit   have, cmd, ed0, ed1;
      @(negedge clk);
      seen[0] = i_done;
      seen[1] = d_done;
      e = '{default: 0};
      have = (q.size() > 0);
      if (have) e = q[0];
      cmd = have && !(e.rd && e.wr) && cyc >= e.iss_start && cyc <= e.iss_end;
      chk("mem_cmd", {30'd0, mem_rd, mem_wr, mem_addr, mem_wdata},
          {30'd0, cmd & e.rd, cmd & e.wr, cmd ? e.addr : 16'h0, cmd ? e.wdata : 16'h0});
      ed0 = have && e.done_cyc == cyc && e.port == 0;
      ed1 = have && e.done_cyc == cyc && e.port == 1;
      chk("i_done", 64'(i_done), 64'(ed0));
      chk("d_done", 64'(d_done), 64'(ed1));
      chk("i_stall", 64'(i_stall), 64'((rd_a[0] | wr_a[0]) & ~ed0));
      chk("d_stall", 64'(d_stall), 64'((rd_a[1] | wr_a[1]) & ~ed1));
      if (!rst_prev)
        chk("reset_outs", {58'd0, mem_rd, mem_wr, i_done, d_done, i_err, d_err}, 64'd0);
      if (have && e.done_cyc == cyc) begin
        bit ill;
        ill = e.rd && e.wr;
        chk("err", {62'd0, d_err, i_err}, {62'd0, ill && e.port == 1, ill && e.port == 0});
        if (e.port == 0) begin
          if (e.rd) chk("i_rdata", 64'(i_rdata), 64'(e.rdata));
          chk("d_rdata_idle", 64'(d_rdata), 64'd0);
        end else begin
          if (e.rd) chk("d_rdata", 64'(d_rdata), 64'(e.rdata));
          chk("i_rdata_idle", 64'(i_rdata), 64'd0);
        end
        $display("txn cyc=%0d port=%s rd=%0b wr=%0b addr=%h wdata=%h rdata=%h", cyc,
                 e.port == 0 ? "I" : "D", e.rd, e.wr, e.addr, e.wdata, e.rdata);
        void'(q.pop_front());
      end
      rst_prev = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(int p, int p_ill);
    int r;
    r = $urandom_range(99);
    rd_a[p]    = (r < p_ill) || (r >= p_ill && r < 55);
    wr_a[p]    = (r < p_ill) || (r >= 55);
    addr_a[p]  = AW'($urandom);
    wdata_a[p] = DW'($urandom);
    act[p]     = 1'b1;
  endtask

  task automatic set_req(int p, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] w);
    rd_a[p] = rd; wr_a[p] = wr; addr_a[p] = a; wdata_a[p] = w; act[p] = 1'b1;
  endtask

  task automatic drop_done();
    for (int p = 0; p < 2; p++) begin
      if (act[p] && seen[p]) begin
        act[p] = 1'b0; rd_a[p] = 1'b0; wr_a[p] = 1'b0;
      end
    end
  endtask

  task automatic rand_cycles(int n, int p_start, int p_re, int p_ill);
    for (int k = 0; k < n; k++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (act[p] && seen[p]) begin
          act[p] = 1'b0; rd_a[p] = 1'b0; wr_a[p] = 1'b0;
          if ($urandom_range(99) < p_re) new_req(p, p_ill);
        end else if (!act[p] && $urandom_range(99) < p_start) begin
          new_req(p, p_ill);
        end
      end
    end
  endtask

  task automatic wait_all(string name);
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < 60) begin
      tick();
      drop_done();
      k++;
    end
    if (act[0] || act[1]) begin
      chk({name, "_timeout"}, 64'({act[1], act[0]}), 64'd0);
      for (int p = 0; p < 2; p++) begin
        act[p] = 1'b0; rd_a[p] = 1'b0; wr_a[p] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rd_a[p] = 1'b0; wr_a[p] = 1'b0; addr_a[p] = '0; wdata_a[p] = '0; act[p] = 1'b0;
    end
    for (int c = 0; c < NST; c++) stall_at[c] = (c > 10 && c < 700) && ($urandom_range(99) < 25);
    repeat (3) tick();
    rst = 1'b1;

    rand_cycles(650, 40, 30, 5);
    rand_cycles(150, 100, 100, 0);
    rand_cycles(40, 0, 0, 0);

    set_req(1, 1'b0, 1'b1, 16'h0040, 16'hBEEF);
    wait_all("d_write");
    set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    wait_all("d_read");
    set_req(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    set_req(1, 1'b0, 1'b1, 16'h0041, 16'h1234);
    wait_all("simultaneous");
    stall_at[cyc + 1] = 1'b1;
    stall_at[cyc + 2] = 1'b1;
    stall_at[cyc + 3] = 1'b1;
    set_req(1, 1'b1, 1'b0, 16'h0041, 16'h0000);
    wait_all("bank_stall");
    set_req(0, 1'b1, 1'b1, 16'h0042, 16'h5555);
    wait_all("illegal");
    set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_all("reset_mid_read");
    repeat (10) tick();

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
